path_sel_pipe: RTL and testbench

- Registered, handshaked successor to the per-lane operand path selector in the vector unit backend.
- One instance per lane, between the register-file rotation path and the execution unit.
- Selects NUM_SRC operands from local register-file data, an absolute lane, a rotated lane, or a broadcast of one local operand.
- Exports local operands to the other lanes and buffers results in a 2-entry skid FIFO with valid/ready flow control.

---
 rtl/path_sel_pipe.sv | 124 ++++++++++++
 tb/tb_path_sel_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/path_sel_pipe.sv
// path_sel_pipe: per-lane operand path selector with a 2-entry valid/ready skid FIFO
//
// Selects NUM_SRC operands from the local register file, an absolute lane,
// a rotated lane (true modulo NUM_LANES) or a broadcast of one local operand,
// and buffers the selection in a 2-entry FIFO toward the execution unit.
// Optional macro PATH_SEL_ERR_CHK_EN adds a sticky out-of-range select flag O_Err.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-low reset
//   I_Valid      request valid
//   O_Ready      request can be accepted (registered count only, 0 during reset)
//   I_Mode       0=LOCAL 1=ABS 2=ROT 3=BCAST
//   I_Sel        lane index / lane offset / operand index
//   I_Src_Data   local operands, operand k at [k*WIDTH +: WIDTH]
//   I_Lane_Data  exchange bus, lane l operand k at [(l*NUM_SRC+k)*WIDTH +: WIDTH]
//   O_Lane_Data  this lane's exchange contribution (I_Src_Data on accept, else 0)
//   O_Valid      output operands valid
//   I_Ready      execution unit accepts the output
//   O_Src_Data   head-of-FIFO operands (0 when empty)
//   O_Err        sticky out-of-range select flag (PATH_SEL_ERR_CHK_EN only)
module path_sel_pipe #(
   parameter int NUM_LANES = 16,
   parameter int NUM_SRC   = 3,
   parameter int WIDTH     = 32,
   parameter int LANE_ID   = 0,
   localparam int LW       = $clog2(NUM_LANES)
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 I_Valid,
   output logic                                 O_Ready,
   input  logic [1:0]                           I_Mode,
   input  logic [LW-1:0]                        I_Sel,
   input  logic [NUM_SRC*WIDTH-1:0]             I_Src_Data,
   input  logic [NUM_LANES*NUM_SRC*WIDTH-1:0]   I_Lane_Data,
   output logic [NUM_SRC*WIDTH-1:0]             O_Lane_Data,
   output logic                                 O_Valid,
   input  logic                                 I_Ready,
`ifdef PATH_SEL_ERR_CHK_EN
   output logic                                 O_Err,
`endif
   output logic [NUM_SRC*WIDTH-1:0]             O_Src_Data
);
   localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   typedef enum logic [1:0] {M_LOCAL, M_ABS, M_ROT, M_BCAST} mode_e;
   logic [WIDTH-1:0]         w_lane [NUM_LANES][NUM_SRC];
   logic [WIDTH-1:0]         w_src  [NUM_SRC];
   logic [NUM_SRC*WIDTH-1:0] w_sel;
   logic [LW-1:0]            w_rot_lane;
   logic [SW-1:0]            w_bsel;
   logic                     w_abs_oob;
   logic                     w_bc_oob;
   logic                     w_fire_in;
   logic                     w_fire_out;
   logic [NUM_SRC*WIDTH-1:0] r_mem [2];
   logic [1:0]               r_cnt;
   logic                     r_head;
   logic                     r_tail;
   for (genvar l = 0; l < NUM_LANES; l++) begin : g_l
      for (genvar k = 0; k < NUM_SRC; k++) begin : g_k
         assign w_lane[l][k] = I_Lane_Data[(l*NUM_SRC+k)*WIDTH +: WIDTH];
      end
   end
   for (genvar k = 0; k < NUM_SRC; k++) begin : g_s
      assign w_src[k] = I_Src_Data[k*WIDTH +: WIDTH];
   end
   // Ready is held low while reset is asserted so nothing is accepted or exported.
   assign O_Ready     = reset & (r_cnt != 2'd2);
   assign w_fire_in   = I_Valid & O_Ready;
   assign w_fire_out  = O_Valid & I_Ready;
   assign O_Valid     = (r_cnt != 2'd0);
   assign O_Src_Data  = O_Valid ? r_mem[r_head] : '0;
   assign O_Lane_Data = w_fire_in ? I_Src_Data : '0;
   assign w_abs_oob   = 32'(I_Sel) >= NUM_LANES;
   assign w_bc_oob    = 32'(I_Sel) >= NUM_SRC;
   assign w_bsel      = SW'(I_Sel);
   // LANE_ID + I_Sel < 3*NUM_LANES, so two conditional subtracts give a true modulo.
   always_comb begin
      int rot;
      rot = LANE_ID + int'(I_Sel);
      rot = (rot >= NUM_LANES) ? rot - NUM_LANES : rot;
      rot = (rot >= NUM_LANES) ? rot - NUM_LANES : rot;
      w_rot_lane = LW'(rot);
   end
   always_comb begin
      w_sel = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_sel[k*WIDTH +: WIDTH] =
            (I_Mode == M_LOCAL) ? w_src[k] :
            (I_Mode == M_ABS)   ? (w_abs_oob ? '0 : w_lane[I_Sel][k]) :
            (I_Mode == M_ROT)   ? w_lane[w_rot_lane][k] :
                                  (w_bc_oob ? '0 : w_src[w_bsel]);
      end
   end
   // Head and tail are single bits over two slots; a write never hits the held head
   // because a write with count=1 goes to the other slot and count=2 blocks writes.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_cnt  <= 2'd0;
         r_head <= 1'b0;
         r_tail <= 1'b0;
         r_mem  <= '{default: '0};
      end else begin
         if (w_fire_in) begin
            r_mem[r_tail] <= w_sel;
            r_tail        <= ~r_tail;
         end
         if (w_fire_out)
            r_head <= ~r_head;
         r_cnt <= r_cnt + 2'(w_fire_in) - 2'(w_fire_out);
      end
   end
`ifdef PATH_SEL_ERR_CHK_EN
   logic r_err;
   always_ff @(posedge clock) begin
      if (!reset)
         r_err <= 1'b0;
      else if (w_fire_in & (((I_Mode == M_ABS) & w_abs_oob) | ((I_Mode == M_BCAST) & w_bc_oob)))
         r_err <= 1'b1;
   end
   assign O_Err = r_err;
`endif
endmodule

// File: tb/tb_path_sel_pipe.sv
// tb_path_sel_pipe: directed self-checking bench for path_sel_pipe
module tb_path_sel_pipe;
   localparam int W  = 32;
   localparam int NS = 3;
   localparam int DW = NS*W;
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;
   logic             valid_a, ready_a, ovalid_a, iready_a;
   logic [1:0]       mode_a;
   logic [3:0]       sel_a;
   logic [DW-1:0]    src_a, lane_out_a, odata_a;
   logic [16*DW-1:0] bus_a;
   logic             valid_b, ready_b, ovalid_b, iready_b;
   logic [1:0]       mode_b;
   logic [3:0]       sel_b;
   logic [DW-1:0]    src_b, lane_out_b, odata_b;
   logic [12*DW-1:0] bus_b;
`ifdef PATH_SEL_ERR_CHK_EN
   logic err_a, err_b;
`endif
   int pass_cnt = 0;
   int tot_cnt  = 0;
   path_sel_pipe #(.NUM_LANES(16), .NUM_SRC(NS), .WIDTH(W), .LANE_ID(5)) u_a (
      .clock(clock), .reset(reset), .I_Valid(valid_a), .O_Ready(ready_a),
      .I_Mode(mode_a), .I_Sel(sel_a), .I_Src_Data(src_a), .I_Lane_Data(bus_a),
      .O_Lane_Data(lane_out_a), .O_Valid(ovalid_a), .I_Ready(iready_a),
`ifdef PATH_SEL_ERR_CHK_EN
      .O_Err(err_a),
`endif
      .O_Src_Data(odata_a));
   path_sel_pipe #(.NUM_LANES(12), .NUM_SRC(NS), .WIDTH(W), .LANE_ID(10)) u_b (
      .clock(clock), .reset(reset), .I_Valid(valid_b), .O_Ready(ready_b),
      .I_Mode(mode_b), .I_Sel(sel_b), .I_Src_Data(src_b), .I_Lane_Data(bus_b),
      .O_Lane_Data(lane_out_b), .O_Valid(ovalid_b), .I_Ready(iready_b),
`ifdef PATH_SEL_ERR_CHK_EN
      .O_Err(err_b),
`endif
      .O_Src_Data(odata_b));
   task automatic tick;
      @(posedge clock);
      #1;
   endtask
   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tot_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         pass_cnt++;
   endtask
   task automatic one_shot(input string name, input logic [1:0] m, input logic [3:0] s,
                           input logic [DW-1:0] d, input logic [DW-1:0] exp);
      mode_a = m; sel_a = s; src_a = d; valid_a = 1'b1; iready_a = 1'b1;
      #1;
      tot_cnt++;
      if (ready_a !== 1'b1) $display("FAIL %s ready: got %b expected 1", name, ready_a);
      else pass_cnt++;
      tick;
      valid_a = 1'b0;
      tot_cnt++;
      if (ovalid_a !== 1'b1) $display("FAIL %s valid: got %b expected 1", name, ovalid_a);
      else pass_cnt++;
      tot_cnt++;
      if (odata_a !== exp) $display("FAIL %s data: got %h expected %h", name, odata_a, exp);
      else pass_cnt++;
      tick;
      tot_cnt++;
      if (ovalid_a !== 1'b0) $display("FAIL %s drain: got %b expected 0", name, ovalid_a);
      else pass_cnt++;
   endtask
   task automatic test_reset;
      valid_a = 1'b1; mode_a = 2'd0; sel_a = '0; src_a = 96'h1; iready_a = 1'b1;
      valid_b = 1'b0; mode_b = 2'd0; sel_b = '0; src_b = '0; iready_b = 1'b1;
      reset = 1'b0;
      tick;
      tick;
      tot_cnt++;
      if (ready_a !== 1'b0) $display("FAIL reset_ready_low: got %b expected 0", ready_a);
      else pass_cnt++;
      chk("reset_lane_out", lane_out_a, '0);
      tot_cnt++;
      if (ovalid_a !== 1'b0) $display("FAIL reset_valid: got %b expected 0", ovalid_a);
      else pass_cnt++;
      chk("reset_data", odata_a, '0);
      valid_a = 1'b0;
      reset = 1'b1;
      #1;
      tot_cnt++;
      if (ready_a !== 1'b1) $display("FAIL reset_ready_high: got %b expected 1", ready_a);
      else pass_cnt++;
`ifdef PATH_SEL_ERR_CHK_EN
      tot_cnt++;
      if (err_a !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_a);
      else pass_cnt++;
`endif
   endtask
   task automatic test_modes;
      one_shot("local", 2'd0, 4'd0, 96'h00000033_00000022_00000011, 96'h00000033_00000022_00000011);
      one_shot("abs9",  2'd1, 4'd9, 96'h0, 96'hC0000902_C0000901_C0000900);
      one_shot("rot14", 2'd2, 4'd14, 96'h0, 96'hC0000302_C0000301_C0000300);
      one_shot("bcast1", 2'd3, 4'd1, 96'h00000033_00000022_00000011, 96'h00000022_00000022_00000022);
`ifdef PATH_SEL_ERR_CHK_EN
      tot_cnt++;
      if (err_a !== 1'b0) $display("FAIL err_before_oob: got %b expected 0", err_a);
      else pass_cnt++;
`endif
      one_shot("bcast3", 2'd3, 4'd3, 96'h00000033_00000022_00000011, 96'h0);
`ifdef PATH_SEL_ERR_CHK_EN
      tot_cnt++;
      if (err_a !== 1'b1) $display("FAIL err_after_oob: got %b expected 1", err_a);
      else pass_cnt++;
`endif
   endtask
   task automatic test_exchange;
      mode_a = 2'd0; sel_a = '0; src_a = 96'h00000007_00000006_00000005; iready_a = 1'b1;
      valid_a = 1'b1;
      #1;
      chk("xchg_fire", lane_out_a, 96'h00000007_00000006_00000005);
      tick;
      valid_a = 1'b0;
      #1;
      chk("xchg_idle", lane_out_a, '0);
      tick;
   endtask
   task automatic test_backpressure;
      localparam logic [DW-1:0] A = 96'hA;
      localparam logic [DW-1:0] B = 96'hB;
      localparam logic [DW-1:0] C = 96'hC;
      mode_a = 2'd0; iready_a = 1'b0;
      src_a = A; valid_a = 1'b1;
      tick;
      src_a = B;
      #1;
      tot_cnt++;
      if (ready_a !== 1'b1) $display("FAIL bp_ready_b: got %b expected 1", ready_a);
      else pass_cnt++;
      tick;
      src_a = C;
      #1;
      tot_cnt++;
      if (ready_a !== 1'b0) $display("FAIL bp_ready_c: got %b expected 0", ready_a);
      else pass_cnt++;
      chk("bp_lane_out_blocked", lane_out_a, '0);
      chk("bp_head_a", odata_a, A);
      tick;
      chk("bp_hold_a", odata_a, A);
      iready_a = 1'b1;
      tick;
      chk("bp_out_b", odata_a, B);
      tot_cnt++;
      if (ready_a !== 1'b1) $display("FAIL bp_ready_back: got %b expected 1", ready_a);
      else pass_cnt++;
      tick;
      valid_a = 1'b0;
      chk("bp_out_c", odata_a, C);
      tick;
      tot_cnt++;
      if (ovalid_a !== 1'b0) $display("FAIL bp_empty: got %b expected 0", ovalid_a);
      else pass_cnt++;
   endtask
   task automatic test_back_to_back;
      mode_a = 2'd0; iready_a = 1'b1;
      for (int i = 0; i < 8; i++) begin
         src_a = {32'(i + 8'h30), 32'(i + 8'h20), 32'(i + 8'h10)};
         valid_a = 1'b1;
         tick;
         tot_cnt++;
         if (ovalid_a !== 1'b1 || ready_a !== 1'b1)
            $display("FAIL stream_%0d valid/ready: got %b/%b expected 1/1", i, ovalid_a, ready_a);
         else
            pass_cnt++;
         chk($sformatf("stream_%0d", i), odata_a, {32'(i + 8'h30), 32'(i + 8'h20), 32'(i + 8'h10)});
      end
      valid_a = 1'b0;
      tick;
      tot_cnt++;
      if (ovalid_a !== 1'b0) $display("FAIL stream_end: got %b expected 0", ovalid_a);
      else pass_cnt++;
   endtask
   task automatic test_npot;
      mode_b = 2'd2; sel_b = 4'd5; valid_b = 1'b1;
      tick;
      chk("npot_rot5", odata_b, 96'hB0000302_B0000301_B0000300);
      sel_b = 4'd15;
      tick;
      chk("npot_rot15", odata_b, 96'hB0000102_B0000101_B0000100);
      mode_b = 2'd1; sel_b = 4'd13;
      tick;
      valid_b = 1'b0;
      tot_cnt++;
      if (ovalid_b !== 1'b1) $display("FAIL npot_abs13_valid: got %b expected 1", ovalid_b);
      else pass_cnt++;
      chk("npot_abs13", odata_b, '0);
`ifdef PATH_SEL_ERR_CHK_EN
      tot_cnt++;
      if (err_b !== 1'b1) $display("FAIL npot_err: got %b expected 1", err_b);
      else pass_cnt++;
`endif
      tick;
   endtask
   task automatic test_reset_mid;
      mode_a = 2'd0; iready_a = 1'b0; valid_a = 1'b1;
      src_a = 96'hD1;
      tick;
      src_a = 96'hD2;
      tick;
      valid_a = 1'b0;
      #1;
      tot_cnt++;
      if (ovalid_a !== 1'b1 || ready_a !== 1'b0)
         $display("FAIL mid_full: valid/ready got %b/%b expected 1/0", ovalid_a, ready_a);
      else
         pass_cnt++;
      reset = 1'b0;
      tick;
      reset = 1'b1;
      #1;
      tot_cnt++;
      if (ovalid_a !== 1'b0) $display("FAIL mid_valid: got %b expected 0", ovalid_a);
      else pass_cnt++;
      chk("mid_data", odata_a, '0);
      tot_cnt++;
      if (ready_a !== 1'b1) $display("FAIL mid_ready: got %b expected 1", ready_a);
      else pass_cnt++;
`ifdef PATH_SEL_ERR_CHK_EN
      tot_cnt++;
      if (err_a !== 1'b0) $display("FAIL mid_err: got %b expected 0", err_a);
      else pass_cnt++;
`endif
      iready_a = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         tot_cnt++;
         if (ovalid_a !== 1'b0) $display("FAIL mid_no_emit_%0d: got %b expected 0", i, ovalid_a);
         else pass_cnt++;
      end
   endtask
   initial begin
      for (int l = 0; l < 16; l++)
         for (int k = 0; k < NS; k++)
            bus_a[(l*NS+k)*W +: W] = 32'hC000_0000 | 32'(l << 8) | 32'(k);
      for (int l = 0; l < 12; l++)
         for (int k = 0; k < NS; k++)
            bus_b[(l*NS+k)*W +: W] = 32'hB000_0000 | 32'(l << 8) | 32'(k);
      test_reset;
      test_modes;
      test_exchange;
      test_backpressure;
      test_back_to_back;
      test_npot;
      test_reset_mid;
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
